fwd_hazard_scoreboard: RTL

//  Parametrised forwarding/hazard unit for the pipelined CPU. Tracks destination registers of
//  in-flight instructions in an internal shift pipeline (one entry per post-issue stage) and,
//  for NUM_SRC source operands of the instruction at issue, selects the youngest in-flight

---
 rtl/fwd_hazard_scoreboard_pkg.sv | 17 +
 rtl/fwd_match_prio.sv | 40 ++++
 rtl/fwd_hazard_scoreboard.sv | 89 ++++++++
 3 files changed

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared constants for the forwarding/hazard scoreboard.
// Entry layout is {valid, rd[ADDR_W], cnt[SEL_W]}; FwdSel value 0 selects the register file.
package fwd_hazard_scoreboard_pkg;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_NUM_SRC   = 2;
  localparam int DEF_FWD_DEPTH = 3;
  localparam int DEF_LOAD_LAT  = 1;

  localparam int          FWD_SEL_REGFILE = 0;
  localparam logic [15:0] STALL_CNT_MAX   = 16'hFFFF;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Compares one source operand against every in-flight entry and picks the youngest producer.
module fwd_match_prio
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FWD_DEPTH = DEF_FWD_DEPTH,
  parameter int SEL_W     = sel_width(DEF_FWD_DEPTH)
) (
  input  logic [FWD_DEPTH-1:0]        entry_valid,
  input  logic [FWD_DEPTH*ADDR_W-1:0] entry_rd,
  input  logic [FWD_DEPTH*SEL_W-1:0]  entry_cnt,
  input  logic [ADDR_W-1:0]           src_addr,
  input  logic                        src_used,
  output logic [SEL_W-1:0]            fwd_sel,
  output logic                        need_stall
);

  logic [FWD_DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_match
      assign match[gi] = src_used & entry_valid[gi]
                       & (entry_rd[gi*ADDR_W +: ADDR_W] == src_addr)
                       & (src_addr != '0);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the last to write.
  always_comb begin
    fwd_sel    = SEL_W'(FWD_SEL_REGFILE);
    need_stall = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        fwd_sel    = SEL_W'(k + 1);
        need_stall = (entry_cnt[k*SEL_W +: SEL_W] != '0);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard unit: shift pipeline of in-flight destinations, per-operand bypass select,
// load-use stall generation and a saturating stall-cycle counter.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int  ADDR_W    = DEF_ADDR_W,
  parameter int  NUM_SRC   = DEF_NUM_SRC,
  parameter int  FWD_DEPTH = DEF_FWD_DEPTH,
  parameter int  LOAD_LAT  = DEF_LOAD_LAT,
  localparam int SEL_W     = sel_width(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      IssueValid,
  input  logic                      IssueRegWrite,
  input  logic                      IssueIsLoad,
  input  logic [ADDR_W-1:0]         IssueRdAddr,
  input  logic [NUM_SRC*ADDR_W-1:0] SrcAddr,
  input  logic [NUM_SRC-1:0]        SrcUsed,
  input  logic                      Flush,
  output logic [NUM_SRC*SEL_W-1:0]  FwdSel,
  output logic                      Stall,
  output logic [15:0]               StallCycles
);

  logic              valid_reg [1:FWD_DEPTH];
  logic [ADDR_W-1:0] rd_reg    [1:FWD_DEPTH];
  logic [SEL_W-1:0]  cnt_reg   [1:FWD_DEPTH];
  logic [15:0]       stall_cnt_reg;

  logic [FWD_DEPTH-1:0]        entry_valid;
  logic [FWD_DEPTH*ADDR_W-1:0] entry_rd;
  logic [FWD_DEPTH*SEL_W-1:0]  entry_cnt;
  logic [NUM_SRC-1:0]          need_stall;
  logic                        alloc;

  generate
    for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_pack
      assign entry_valid[gi]                 = valid_reg[gi+1];
      assign entry_rd[gi*ADDR_W +: ADDR_W]   = rd_reg[gi+1];
      assign entry_cnt[gi*SEL_W +: SEL_W]    = cnt_reg[gi+1];
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_match_prio #(
        .ADDR_W   (ADDR_W),
        .FWD_DEPTH(FWD_DEPTH),
        .SEL_W    (SEL_W)
      ) u_match (
        .entry_valid(entry_valid),
        .entry_rd   (entry_rd),
        .entry_cnt  (entry_cnt),
        .src_addr   (SrcAddr[gi*ADDR_W +: ADDR_W]),
        .src_used   (SrcUsed[gi]),
        .fwd_sel    (FwdSel[gi*SEL_W +: SEL_W]),
        .need_stall (need_stall[gi])
      );
    end
  endgenerate

  assign Stall       = (|need_stall) & IssueValid & ~Flush;
  assign alloc       = IssueValid & IssueRegWrite & (IssueRdAddr != '0) & ~Stall & ~Flush;
  assign StallCycles = stall_cnt_reg;

  // The pipeline advances every cycle; a stall just means entry 1 receives a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        valid_reg[k] <= 1'b0;
        rd_reg[k]    <= '0;
        cnt_reg[k]   <= '0;
      end
      stall_cnt_reg <= '0;
    end else begin
      valid_reg[1] <= alloc;
      rd_reg[1]    <= IssueRdAddr;
      cnt_reg[1]   <= IssueIsLoad ? SEL_W'(LOAD_LAT) : '0;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        valid_reg[k] <= (k == 2) ? (valid_reg[k-1] & ~Flush) : valid_reg[k-1];
        rd_reg[k]    <= rd_reg[k-1];
        cnt_reg[k]   <= (cnt_reg[k-1] != '0) ? cnt_reg[k-1] - SEL_W'(1) : '0;
      end
      if (Stall && (stall_cnt_reg != STALL_CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

endmodule
